// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multi-cycle unsigned multiply/divide unit:
// op and state encodings plus the ex_signals field positions used by the decoder.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } muldiv_state_t;

  // Where the decoder places the muldiv start flag and op field inside ex_signals.
  localparam int EX_MULDIV_START_BIT = 0;
  localparam int EX_MULDIV_OP_LSB    = 1;
  localparam int EX_MULDIV_OP_MSB    = 2;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

  // MULH and REMU take the upper half of the working register.
  function automatic logic op_is_hi(input muldiv_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the ID/EX register side and the muldiv unit.
// Handshake: start is a level held by ID/EX; the op is accepted on the edge where
// the unit is IDLE, start=1 and flush=0 (stall is high in that cycle); done is a one-cycle
// pulse on which result/rd_addr_out/div_by_zero are valid.
interface ex_muldiv_unit_if #(parameter int WIDTH = 16);
  import ex_muldiv_unit_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       rd_addr_in;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       rd_addr_out;
  logic             div_by_zero;
  muldiv_state_t    dbg_state;

  modport master (
    output start, op, a, b, rd_addr_in, flush,
    input  stall, busy, done, result, rd_addr_out, div_by_zero, dbg_state
  );

  modport slave (
    input  start, op, a, b, rd_addr_in, flush,
    output stall, busy, done, result, rd_addr_out, div_by_zero, dbg_state
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared working register: shift-add multiply
// (acc = {hi, multiplier}) or restoring divide (acc = {remainder, quotient}).
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = (shifted >= {1'b0, m});
    // When ge holds the true difference is below m, so the low WIDTH bits are exact.
    diff    = shifted[WIDTH-1:0] - m;
    if (is_div) begin
      acc_next = {(ge ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle unsigned MUL/MULH/DIVU/REMU: WIDTH iterations in RUN,
// one-cycle done pulse, and a stall that freezes ID/EX and IF/ID while the op is in flight.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int ITER = WIDTH;
  localparam int CW   = $clog2(WIDTH);

  muldiv_state_t      state, state_n;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   m;
  muldiv_op_t         op_q;
  logic [3:0]         rd_q;
  logic               accept, last;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         rd_out_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_q)),
    .acc      (acc),
    .m        (m),
    .acc_next (acc_next)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      S_IDLE: if (bus.start && !bus.flush) begin
        accept  = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: if (bus.flush) begin
        state_n = S_IDLE;
      end else if (cnt == CW'(ITER - 1)) begin
        last    = 1'b1;
        state_n = S_DONE;
      end
      // DONE always retires; start seen here belongs to the op just finished.
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == S_RUN);
      done_q <= last;
      dbz_q  <= 1'b0;
      if (accept) begin
        op_q <= bus.op;
        rd_q <= bus.rd_addr_in;
        cnt  <= '0;
        // Multiply iterates over b with a as addend; divide shifts a against divisor b.
        m    <= op_is_div(bus.op) ? bus.b : bus.a;
        acc  <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? bus.a : bus.b)};
      end else if (state == S_RUN) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        result_q <= op_is_hi(op_q) ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        rd_out_q <= rd_q;
        dbz_q    <= op_is_div(op_q) && (m == '0);
      end
    end
  end

  assign bus.stall       = accept || (state == S_RUN);
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.rd_addr_out = rd_out_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dbg_state   = state;
endmodule
